rr_mux_arbiter16: RTL and testbench
===================================

Name: rr_mux_arbiter16

Overview:
- Round-robin arbiter and sequencer for the shared 16-input, 32-bit mux datapath.
- Accepts up to 16 requesters and grants one at a time.
- Drives the mux 4-bit select so the granted requester's 32-bit word reaches a single downstream consumer through a valid/ready handshake.
- Bounds each grant to a maximum burst of beats so no requester can starve the others.

Parameters:
- MAX_BURST, 4, maximum beats per grant; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req  input  16  request vector; req[i] high means requester i has a word on mux input i.
- out_ready  input  1  downstream consumer accepts the current word.
- select  output  4  mux select; connects directly to the 16:1 mux select input.
- grant  output  16  one-hot grant; bit select is set while in GRANT, otherwise all zero.
- out_valid  output  1  mux output word is valid this cycle.
- ack  output  16  one-hot beat acknowledge to the requesters.
- busy  output  1  high while in GRANT.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- States: IDLE and GRANT, held in a state register.
- Internal state:
  - ptr[3:0], the round-robin start index.
  - beats[7:0], the beat counter for the current grant.
- Reset (at clk edge with reset=1): state=IDLE, select=0, grant=0, ptr=0, beats=0. Outputs out_valid=0, ack=0, busy=0.
- Reset has priority over all other events, including mid-burst. An in-flight beat on that edge is not acknowledged.
- IDLE:
  - If req==0, stay in IDLE; outputs held at their reset values except select, which keeps its last value.
  - If req!=0, the winner is the first set bit scanning ptr, ptr+1, ..., ptr+15 (mod 16).
  - Next edge: select=winner, grant=one-hot(winner), beats=0, state=GRANT.
  - Arbitration latency is exactly 1 cycle from req high in IDLE to grant.
- GRANT:
  - out_valid = req[select], combinational.
  - Beat condition: out_valid && out_ready.
  - ack = grant when a beat occurs, else 0 (combinational).
  - On a beat, beats increments.
  - The grant ends at the edge where either:
    - a beat occurs with beats==MAX_BURST-1, or
    - req[select]==0 (requester released).
  - At grant end: state=IDLE, grant=0, ptr=select+1 (4-bit wrap; 15 wraps to 0), beats=0.
  - out_ready low with req held: state, beats and select hold. There is no timeout.
- Inter-grant gap: one IDLE cycle is mandatory between consecutive grants, including re-granting the same requester.
- Fairness:
  - A requester that was just served has the lowest priority at the next arbitration.
  - With all 16 requesting continuously, the grant order is ptr, ptr+1, ..., wrapping.
- Requests from non-granted requesters during GRANT are ignored until the next IDLE.
- MAX_BURST=1: every beat ends the grant.
- select changes only on the IDLE->GRANT edge. The mux input therefore never changes within a grant.

Test Plan:
- Reset, then req=16'h0001 held, out_ready=1, MAX_BURST=4:
  - grant=16'h0001 and select=0 one cycle after req.
  - 4 consecutive ack pulses, then 1 IDLE cycle, then re-granted.
- req=16'h0081 held, out_ready=1:
  - grant order 0, 7, 0, 7; each grant gives 4 beats.
  - ptr=1 after the first grant, and ptr=8 after the second.
- req=16'hFFFF held, MAX_BURST=1:
  - select sequence 0, 1, 2, ..., 15, 0, with one IDLE cycle between grants.
  - ack is one-hot matching select.
- Requester 3 granted; drop req[3] after 2 beats:
  - out_valid falls the same cycle; state goes to IDLE on the next edge; ptr=4; no further ack[3].
- Requester 5 granted with out_ready=0 for 10 cycles:
  - out_valid=1, ack=0, beats=0, select=5 held throughout.
  - Raise out_ready: 4 beats complete normally.
- Assert reset for 1 cycle mid-burst (beats=2):
  - Next cycle state=IDLE, grant=0, select=0, ptr=0, out_valid=0.
  - Arbitration restarts from index 0.

Source files
------------

// File: rtl/rr_mux_arbiter16.sv
// Round-robin arbiter driving the select of a shared 16:1, 32-bit mux.
// One grant at a time, bounded to MAX_BURST valid/ready beats, with a mandatory idle gap between grants.
//
// state   | meaning
// S_IDLE  | no owner; arbitrate among req starting at ptr
// S_GRANT | requester `select` owns the mux until burst limit or release
module rr_mux_arbiter16 #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] req,
  input  logic        out_ready,
  output logic [3:0]  select,
  output logic [15:0] grant,
  output logic        out_valid,
  output logic [15:0] ack,
  output logic        busy
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

  state_t      state_q, state_d;
  logic [3:0]  select_q, select_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [7:0]  beats_q, beats_d;
  logic [3:0]  winner;
  logic [3:0]  scan_idx;
  logic        found;
  logic        beat;
  logic        grant_end;

  // First set request scanning ptr, ptr+1, ... with 4-bit wrap.
  always_comb begin
    winner   = ptr_q;
    found    = 1'b0;
    scan_idx = ptr_q;
    for (int i = 0; i < 16; i++) begin
      scan_idx = ptr_q + 4'(i);
      if (!found && req[scan_idx]) begin
        winner = scan_idx;
        found  = 1'b1;
      end
    end
  end

  // A beat coinciding with reset is discarded, so it is not acknowledged either.
  assign beat      = (state_q == S_GRANT) && req[select_q] && out_ready && !reset;
  assign grant_end = (state_q == S_GRANT) &&
                     (!req[select_q] || (beat && (beats_q == LAST_BEAT)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      select_q <= 4'd0;
      ptr_q    <= 4'd0;
      beats_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      select_q <= select_d;
      ptr_q    <= ptr_d;
      beats_q  <= beats_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    select_d = select_q;
    ptr_d    = ptr_q;
    beats_d  = beats_q;
    case (state_q)
      S_IDLE: begin
        if (req != 16'd0) begin
          state_d  = S_GRANT;
          select_d = winner;
          beats_d  = 8'd0;
        end
      end
      S_GRANT: begin
        if (grant_end) begin
          state_d = S_IDLE;
          ptr_d   = select_q + 4'd1;
          beats_d = 8'd0;
        end else if (beat) begin
          beats_d = beats_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == S_GRANT);
    select    = select_q;
    grant     = busy ? (16'd1 << select_q) : 16'd0;
    out_valid = busy && req[select_q];
    ack       = beat ? grant : 16'd0;
  end

endmodule

// File: tb/tb_rr_mux_arbiter16.sv
// Scoreboard bench for rr_mux_arbiter16: two instances (MAX_BURST=4 and 1) share stimulus;
// a reference model queues per-cycle expectations and a negedge monitor pops and compares.
module tb_rr_mux_arbiter16;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] req;
  logic        out_ready;

  logic [3:0]  select4, select1;
  logic [15:0] grant4, grant1, ack4, ack1;
  logic        valid4, valid1, busy4, busy1;

  always #5 clk = ~clk;

  rr_mux_arbiter16 #(.MAX_BURST(4)) dut4 (
    .clk(clk), .reset(reset), .req(req), .out_ready(out_ready),
    .select(select4), .grant(grant4), .out_valid(valid4), .ack(ack4), .busy(busy4)
  );

  rr_mux_arbiter16 #(.MAX_BURST(1)) dut1 (
    .clk(clk), .reset(reset), .req(req), .out_ready(out_ready),
    .select(select1), .grant(grant1), .out_valid(valid1), .ack(ack1), .busy(busy1)
  );

  typedef struct packed {
    logic [15:0] grant;
    logic [3:0]  sel;
    logic        valid;
    logic [15:0] ack;
    logic        busy;
  } exp_t;

  exp_t exp_q4[$];
  exp_t exp_q1[$];
  int   beat_q4[$];
  int   beat_q1[$];

  // Reference model: who owns the mux, where the next scan starts, beats used so far.
  bit m_busy[2];
  int m_sel[2];
  int m_ptr[2];
  int m_beats[2];

  int  checks = 0;
  int  passes = 0;
  bit  mon_en = 1'b0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] want);
    checks++;
    if (act === want) passes++;
    else $display("FAIL %s actual=%h required=%h at t=%0t", nm, act, want, $time);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 1'b0; m_sel[d] = 0; m_ptr[d] = 0; m_beats[d] = 0;
    end
  endtask

  // Expected outputs for the current cycle, then the effect of the coming edge.
  task automatic model_cycle(input int d, input int mb);
    exp_t e;
    bit   beat;
    int   w;
    e.busy  = m_busy[d];
    e.sel   = 4'(m_sel[d]);
    e.grant = m_busy[d] ? (16'd1 << m_sel[d]) : 16'd0;
    e.valid = m_busy[d] && req[m_sel[d]];
    beat    = e.valid && out_ready && !reset;
    e.ack   = beat ? e.grant : 16'd0;
    if (d == 0) begin
      exp_q4.push_back(e);
      if (beat) beat_q4.push_back(m_sel[d]);
    end else begin
      exp_q1.push_back(e);
      if (beat) beat_q1.push_back(m_sel[d]);
    end
    if (reset) begin
      m_busy[d] = 1'b0; m_sel[d] = 0; m_ptr[d] = 0; m_beats[d] = 0;
    end else if (!m_busy[d]) begin
      if (req != 16'd0) begin
        w = -1;
        for (int k = 0; k < 16; k++)
          if (w < 0 && req[(m_ptr[d] + k) % 16]) w = (m_ptr[d] + k) % 16;
        m_sel[d] = w; m_busy[d] = 1'b1; m_beats[d] = 0;
      end
    end else begin
      if (beat) m_beats[d]++;
      if (!req[m_sel[d]] || (beat && m_beats[d] == mb)) begin
        m_busy[d] = 1'b0; m_ptr[d] = (m_sel[d] + 1) % 16; m_beats[d] = 0;
      end
    end
  endtask

  task automatic drive(input logic r, input logic [15:0] rq, input logic rdy, input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      reset = r; req = rq; out_ready = rdy;
      model_cycle(0, 4);
      model_cycle(1, 1);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    int   b;
    if (mon_en) begin
      if (exp_q4.size() > 0) begin
        e = exp_q4.pop_front();
        chk("b4_grant", grant4, e.grant);
        chk("b4_select", 16'(select4), 16'(e.sel));
        chk("b4_valid", 16'(valid4), 16'(e.valid));
        chk("b4_ack", ack4, e.ack);
        chk("b4_busy", 16'(busy4), 16'(e.busy));
      end
      if (exp_q1.size() > 0) begin
        e = exp_q1.pop_front();
        chk("b1_grant", grant1, e.grant);
        chk("b1_select", 16'(select1), 16'(e.sel));
        chk("b1_valid", 16'(valid1), 16'(e.valid));
        chk("b1_ack", ack1, e.ack);
        chk("b1_busy", 16'(busy1), 16'(e.busy));
      end
      if (ack4 != 16'd0) begin
        if (beat_q4.size() == 0) chk("b4_unexpected_beat", ack4, 16'd0);
        else begin
          b = beat_q4.pop_front();
          chk("b4_beat_owner", ack4, 16'd1 << b);
        end
      end
      if (ack1 != 16'd0) begin
        if (beat_q1.size() == 0) chk("b1_unexpected_beat", ack1, 16'd0);
        else begin
          b = beat_q1.pop_front();
          chk("b1_beat_owner", ack1, 16'd1 << b);
        end
      end
    end
  end

  initial begin
    logic [15:0] rq;
    logic        rdy;
    logic        rst;
    reset = 1'b1; req = 16'd0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    model_reset();
    mon_en = 1'b1;

    // Reset state, then a single steady requester.
    drive(1'b1, 16'h0000, 1'b1, 2);
    drive(1'b0, 16'h0000, 1'b1, 2);
    drive(1'b0, 16'h0001, 1'b1, 14);
    // Two requesters alternate 0,7,0,7.
    drive(1'b1, 16'h0000, 1'b1, 1);
    drive(1'b0, 16'h0081, 1'b1, 24);
    // Everyone requesting: full rotation.
    drive(1'b1, 16'h0000, 1'b1, 1);
    drive(1'b0, 16'hFFFF, 1'b1, 40);
    // Requester 3 released after two beats.
    drive(1'b1, 16'h0000, 1'b1, 1);
    drive(1'b0, 16'h0008, 1'b1, 3);
    drive(1'b0, 16'h0000, 1'b1, 3);
    drive(1'b0, 16'h0010, 1'b1, 4);
    // Requester 5 stalled by the consumer, then drained.
    drive(1'b1, 16'h0000, 1'b1, 1);
    drive(1'b0, 16'h0020, 1'b0, 11);
    drive(1'b0, 16'h0020, 1'b1, 6);
    // Reset mid-burst, then arbitration restarts from index 0.
    drive(1'b1, 16'h0000, 1'b1, 1);
    drive(1'b0, 16'h0040, 1'b1, 3);
    drive(1'b1, 16'h0041, 1'b1, 1);
    drive(1'b0, 16'h0041, 1'b1, 12);
    // Randomised traffic with occasional reset.
    rq = 16'h1234;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0)
        rq = 16'($urandom) & 16'($urandom) & (($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'($urandom));
      rdy = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 299) == 0);
      drive(rst, rq, rdy, 1);
    end
    drive(1'b0, 16'h0000, 1'b1, 8);

    @(negedge clk);
    #1;
    chk("b4_exp_drain", 16'(exp_q4.size()), 16'd0);
    chk("b1_exp_drain", 16'(exp_q1.size()), 16'd0);
    chk("b4_beat_drain", 16'(beat_q4.size()), 16'd0);
    chk("b1_beat_drain", 16'(beat_q1.size()), 16'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
